wire_arbiter: RTL and testbench
===============================

WIRE_ARBITER -- requirements
Module: wire_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the single output line; legal range 2..8.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles before forced release; legal range 1..255; used only when WIRE_ARB_TIMEOUT_EN is defined.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset; synchronous and active-high.
REQ-005 Port req, input, N_REQ bits: bit i high means requester i wants the shared line.
REQ-006 Port in_bus, input, N_REQ bits: bit i is the data bit driven by requester i.
REQ-007 Port gnt, output, N_REQ bits: registered, one-hot or zero; bit i high means requester i owns the line.
REQ-008 Port owner, output, clog2(N_REQ) bits: registered index of the current or last owner.
REQ-009 Port busy, output, 1 bit: registered; high when any gnt bit is high.
REQ-010 Port out, output, 1 bit: registered shared line.

Function
REQ-011 States are IDLE (gnt=0) and GRANT (exactly one gnt bit high); busy shall equal state==GRANT.
REQ-012 Round-robin pointer rr_ptr: search order is rr_ptr, rr_ptr+1, ... wrapping modulo N_REQ; the first requester with req high wins.
REQ-013 IDLE: if any req bit is high at edge k, the winner's gnt bit, owner and busy are high from edge k; with no req, remain IDLE.
REQ-014 GRANT: out at edge k+1 equals in_bus[owner] sampled at edge k+1, i.e. out is in_bus[owner] delayed one cycle; in IDLE, out is 0 at the next edge.
REQ-015 Release: when req[owner] is low at an edge, set rr_ptr = (owner+1) mod N_REQ. If another req bit is high, grant the next winner at that same edge with no idle cycle, searching from the new rr_ptr and excluding the old owner. Otherwise go to IDLE.
REQ-016 gnt shall never have more than one bit high, and shall never have a bit high for a requester whose req was low at the granting edge.
REQ-017 owner holds its last value in IDLE.
REQ-018 Changes to req bits of non-owners while in GRANT shall not affect gnt until release.
REQ-019 in_bus bits of non-owners shall never influence out.

Reset
REQ-020 rst high at an edge forces gnt=0, owner=0, busy=0, out=0, rr_ptr=0, hold counter=0, state=IDLE, regardless of req. This includes reset during GRANT.
REQ-021 In the first edge with rst low, arbitration proceeds per REQ-013 from rr_ptr=0.

Configuration
REQ-022 Macro WIRE_ARB_TIMEOUT_EN, when defined, adds an 8-bit hold counter. The counter is cleared on each new grant and increments each GRANT cycle.
REQ-023 With WIRE_ARB_TIMEOUT_EN, when the counter reaches MAX_HOLD and another req bit is high, the owner is released as in REQ-015 even if req[owner] is high.
REQ-024 With WIRE_ARB_TIMEOUT_EN, if no other requester is pending, the counter saturates at MAX_HOLD and the grant is held.
REQ-025 Without WIRE_ARB_TIMEOUT_EN, no counter exists and a grant is held for as long as req[owner] stays high.

Verification
REQ-026 Reset then req=4'b0000 for 5 cycles -> gnt=0, busy=0, out=0 throughout.
REQ-027 Priority order: after reset, req=4'b1010 -> gnt=4'b0010 and owner=1 at the next edge. Then drop req[1] -> gnt=4'b1000 and owner=3 at the same edge, with no idle cycle.
REQ-028 Data path: requester 2 granted, in_bus[2] toggles 0,1,1,0 while in_bus[0] is held at 1 -> out follows 0,1,1,0 one cycle later; in_bus[0] is never visible on out.
REQ-029 Fairness: req=4'b1111 held, each owner dropping its req for one cycle after 2 cycles of grant -> grant order 0,1,2,3,0.
REQ-030 Mid-grant reset: rst asserted during a grant to requester 3 -> gnt, busy and out are 0 at that edge. After rst deasserts with req=4'b1001, owner=0.
REQ-031 Timeout, with WIRE_ARB_TIMEOUT_EN and MAX_HOLD=4: req=4'b0011 held -> owner 0 for 4 cycles, then owner 1 for 4 cycles, alternating. The same stimulus without the macro -> owner 0 indefinitely.

Source files
------------

// File: rtl/wire_arbiter.sv
// wire_arbiter: round-robin arbiter that hands one shared output line to one
// of N_REQ requesters at a time and forwards the owner's data bit, registered.
// Optional feature macro: WIRE_ARB_TIMEOUT_EN adds an 8-bit hold counter that
// forces the owner off the line after MAX_HOLD grant cycles when others wait.
module wire_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           in_bus,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic                       out
);

    localparam int unsigned OW = $clog2(N_REQ);

    // Elaboration-time parameter range checks
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("wire_arbiter: N_REQ out of range 2..8");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("wire_arbiter: MAX_HOLD out of range 1..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      rr_q, rr_d;
    logic               out_q, out_d;
    logic [N_REQ-1:0]   others;
    logic [OW-1:0]      next_ptr;
    logic [OW-1:0]      win;
    logic               timeout;

    // First requester with req high, searching from ptr and wrapping modulo N_REQ
    function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [OW-1:0]    ptr);
        logic [OW-1:0]    sel;
        logic             found;
        int unsigned      idx;
        logic [N_REQ-1:0] sh;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            sh = r >> idx;
            if (!found && sh[0]) begin
                sel   = OW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

`ifdef WIRE_ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic [8:0] hold_inc;

    // The counter reaching MAX_HOLD on this edge marks the hold budget as spent
    assign hold_inc = {1'b0, hold_q} + 9'd1;
    assign timeout  = (hold_inc >= 9'(MAX_HOLD));
`else
    assign timeout  = 1'b0;
`endif

    // Requesters other than the owner, and the pointer used after a release
    assign others   = req & ~(N_REQ'(1) << owner_q);
    assign next_ptr = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        out_d   = 1'b0;
        win     = '0;
`ifdef WIRE_ARB_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|req) begin
                    win     = rr_pick(req, rr_q);
                    state_d = GRANT;
                    owner_d = win;
                    gnt_d   = N_REQ'(1) << win;
`ifdef WIRE_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                out_d = in_bus[owner_q];
                if (!req[owner_q] || (timeout && (|others))) begin
                    rr_d = next_ptr;
                    if (|others) begin
                        win     = rr_pick(others, next_ptr);
                        owner_d = win;
                        gnt_d   = N_REQ'(1) << win;
`ifdef WIRE_ARB_TIMEOUT_EN
                        hold_d  = '0;
`endif
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else begin
`ifdef WIRE_ARB_TIMEOUT_EN
                    hold_d = timeout ? 8'(MAX_HOLD) : hold_inc[7:0];
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            out_q   <= 1'b0;
`ifdef WIRE_ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            out_q   <= out_d;
`ifdef WIRE_ARB_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = (state_q == GRANT);
    assign out   = out_q;

endmodule

// File: tb/tb_wire_arbiter.sv
// Self-checking bench for wire_arbiter: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wire_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;
    localparam int OW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  in_bus = '0;
    logic [N-1:0]  gnt;
    logic [OW-1:0] owner;
    logic          busy;
    logic          out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wire_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .in_bus (in_bus),
        .gnt    (gnt),
        .owner  (owner),
        .busy   (busy),
        .out    (out)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: who owns the line, whether it is held, rotation start, hold length
    int m_owner = 0;
    int m_rr    = 0;
    int m_hold  = 0;
    bit m_busy  = 0;
    bit m_out   = 0;
    bit m_valid = 0;

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        logic [N-1:0] sh;
        for (int i = 0; i < N; i++) begin
            sh = r >> ((ptr + i) % N);
            if (sh[0]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    // Behavioural reference advanced on every rising edge
    always @(posedge clk) begin
        logic [N-1:0] sh;
        logic [N-1:0] others;
        bit           to;
        if (rst) begin
            m_owner = 0; m_rr = 0; m_hold = 0; m_busy = 0; m_out = 0; m_valid = 1;
        end else begin
            sh    = in_bus >> m_owner;
            m_out = m_busy && sh[0];
            if (!m_busy) begin
                if (req != '0) begin
                    m_owner = pick(req, m_rr);
                    m_busy  = 1;
                    m_hold  = 0;
                end
            end else begin
                sh     = req >> m_owner;
                others = req & ~(N'(1) << m_owner);
`ifdef WIRE_ARB_TIMEOUT_EN
                to = (m_hold + 1 >= MH) && (others != '0);
`else
                to = 0;
`endif
                if (!sh[0] || to) begin
                    m_rr = (m_owner + 1) % N;
                    if (others != '0) begin
                        m_owner = pick(others, m_rr);
                        m_hold  = 0;
                    end else begin
                        m_busy = 0;
                    end
                end else begin
                    m_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge once reset has been seen
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_gnt",   int'(gnt),   m_busy ? (1 << m_owner) : 0);
            chk("model_owner", int'(owner), m_owner);
            chk("model_busy",  int'(busy),  int'(m_busy));
            chk("model_out",   int'(out),   int'(m_out));
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int pat [4];
        int ord [5];
        logic [N-1:0] flip;
        pat = '{0, 1, 1, 0};
        ord = '{0, 1, 2, 3, 0};

        // Idle after reset: nothing granted for five cycles
        req = '0;
        do_reset();
        chk("rst_owner", int'(owner), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_gnt",  int'(gnt),  0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_out",  int'(out),  0);
        end

        // Priority from pointer 0, then hand-over without an idle cycle
        req = 4'b1010;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ignores_req", int'(gnt), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("prio_gnt",   int'(gnt),   4'b0010);
        chk("prio_owner", int'(owner), 1);
        req = 4'b1000;
        @(negedge clk);
        chk("handover_gnt",   int'(gnt),   4'b1000);
        chk("handover_owner", int'(owner), 3);
        chk("handover_busy",  int'(busy),  1);

        // Data path: out follows in_bus[2] one cycle late, in_bus[0] never leaks
        req    = 4'b0100;
        in_bus = 4'b0001;
        do_reset();
        @(negedge clk);
        chk("data_owner", int'(owner), 2);
        for (int i = 0; i < 4; i++) begin
            in_bus = {1'b0, pat[i][0], 1'b0, 1'b1};
            @(negedge clk);
            chk("data_out", int'(out), pat[i]);
        end

        // Fairness: everyone requests, each owner yields after two cycles
        req    = 4'b1111;
        in_bus = '0;
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("fair_owner", int'(owner), ord[k]);
            @(negedge clk);
            req = 4'b1111 & ~(4'(1) << ord[k]);
            @(negedge clk);
            req = 4'b1111;
        end

        // Reset in the middle of a grant to requester 3
        req    = 4'b1000;
        in_bus = 4'b1000;
        do_reset();
        @(negedge clk);
        chk("mid_gnt_pre", int'(gnt), 4'b1000);
        @(negedge clk);
        chk("mid_out_pre", int'(out), 1);
        rst = 1'b1;
        req = 4'b1001;
        @(negedge clk);
        chk("mid_rst_gnt",   int'(gnt),   0);
        chk("mid_rst_busy",  int'(busy),  0);
        chk("mid_rst_out",   int'(out),   0);
        chk("mid_rst_owner", int'(owner), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_owner", int'(owner), 0);
        chk("post_rst_gnt",   int'(gnt),   4'b0001);

        // Two steady requesters: timeout alternation, or a permanent holder
        req    = 4'b0011;
        in_bus = '0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
`ifdef WIRE_ARB_TIMEOUT_EN
            chk("hold_owner", int'(owner), (c / MH) % 2);
`else
            chk("hold_owner", int'(owner), 0);
`endif
        end

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            flip = '0;
            for (int b = 0; b < N; b++) begin
                flip[b] = ($urandom_range(0, 3) == 0);
            end
            req    = req ^ flip;
            in_bus = N'($urandom);
            rst    = ($urandom_range(0, 199) == 0);
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
